keyspace_gen: RTL and testbench

- Parametrised candidate-plaintext generator for the brute-force MD5 search path.
- Enumerates every string over a contiguous byte range (default 'a'..'z'), fastest-varying character in the low byte.
- Optional growth from length 1 up to `MAX_LEN`; a start point can be loaded so several hash cores can split the keyspace.
- Feeds the hash core through a valid/ready handshake at up to one candidate per clock.

---
 rtl/keyspace_gen_if.sv | 22 ++
 rtl/keyspace_gen.sv | 135 +++++++++++++
 tb/tb_keyspace_gen.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/keyspace_gen_if.sv
// Candidate stream from keyspace_gen to a hash core.
// Valid/ready handshake carrying the candidate string and its length.
interface keyspace_gen_if;
    logic [127:0] q;
    logic [4:0]   len;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output q,
        output len,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  q,
        input  len,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/keyspace_gen.sv
// Brute-force candidate generator over CHAR_LO..CHAR_HI, char 0 fastest.
// Define KEYSPACE_VARLEN_EN to grow from length 1 up to MAX_LEN.
module keyspace_gen #(
    parameter int MAX_LEN = 5,
    parameter int CHAR_LO = 97,
    parameter int CHAR_HI = 122
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           load,
    input  logic [127:0]   load_q,
    input  logic [4:0]     load_len,
    keyspace_gen_if.master cand,
    output logic           overflow
);

    localparam logic [7:0] LO   = CHAR_LO[7:0];
    localparam logic [7:0] HI   = CHAR_HI[7:0];
    localparam logic [4:0] MAXL = 5'(MAX_LEN);
`ifdef KEYSPACE_VARLEN_EN
    localparam logic [4:0] RST_LEN = 5'd1;
`else
    localparam logic [4:0] RST_LEN = MAXL;
`endif

    function automatic logic [127:0] fill(
        input logic [4:0] n,
        input logic [7:0] b
    );
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < int'(n)) r[8*i +: 8] = b;
        end
        return r;
    endfunction

    logic [127:0] q_q, q_d, inc_q;
    logic [4:0]   len_q, ld_len;
    logic         valid_q, valid_d;
    logic         ovf_q, ovf_d;
    logic         carry, xfer;

    // Ripple carry over the active chars; carry out means wrap of all.
    always_comb begin
        inc_q = q_q;
        carry = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i < int'(len_q) && carry) begin
                if (q_q[8*i +: 8] >= HI) begin
                    inc_q[8*i +: 8] = LO;
                end else begin
                    inc_q[8*i +: 8] = q_q[8*i +: 8] + 8'd1;
                    carry = 1'b0;
                end
            end
        end
    end

`ifdef KEYSPACE_VARLEN_EN
    logic [4:0] len_d;

    always_comb begin
        if (load_len == 5'd0)     ld_len = 5'd1;
        else if (load_len > MAXL) ld_len = MAXL;
        else                      ld_len = load_len;
    end

    always_ff @(posedge clk) begin
        if (rst) len_q <= RST_LEN;
        else     len_q <= len_d;
    end
`else
    logic unused_load_len;
    assign unused_load_len = ^load_len;
    assign ld_len = MAXL;
    assign len_q  = MAXL;
`endif

    assign xfer = valid_q && cand.out_ready;

    always_comb begin
        q_d   = q_q;
        ovf_d = ovf_q;
`ifdef KEYSPACE_VARLEN_EN
        len_d = len_q;
`endif
        if (load) begin
            q_d   = load_q & fill(ld_len, 8'hFF);
            ovf_d = 1'b0;
`ifdef KEYSPACE_VARLEN_EN
            len_d = ld_len;
`endif
        end else if (xfer) begin
            if (!carry) begin
                q_d = inc_q;
            end else begin
`ifdef KEYSPACE_VARLEN_EN
                if (len_q < MAXL) begin
                    len_d = len_q + 5'd1;
                    q_d   = fill(len_q + 5'd1, LO);
                end else begin
                    ovf_d = 1'b1;
                end
`else
                ovf_d = 1'b1;
`endif
            end
        end
        // A pending candidate keeps valid until consumed or discarded.
        valid_d = valid_q;
        if (!valid_q || cand.out_ready || load) begin
            valid_d = en && !ovf_d && !load;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q     <= fill(RST_LEN, LO);
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            q_q     <= q_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign cand.q         = q_q;
    assign cand.len       = len_q;
    assign cand.out_valid = valid_q;
    assign overflow       = ovf_q;

endmodule

// File: tb/tb_keyspace_gen.sv
// Self-checking bench for keyspace_gen with MAX_LEN=3 over 'a'..'c'.
// Works with KEYSPACE_VARLEN_EN either defined or not.
module tb_keyspace_gen;

    localparam int NCH = 3;
    localparam int ML  = 3;
    localparam logic [7:0] LO = 8'h61;
`ifdef KEYSPACE_VARLEN_EN
    localparam bit VAR = 1'b1;
    localparam int NTOT = 39;
    localparam logic [127:0] RSTQ = 128'h61;
    localparam int RSTL = 1;
`else
    localparam bit VAR = 1'b0;
    localparam int NTOT = 27;
    localparam logic [127:0] RSTQ = 128'h616161;
    localparam int RSTL = 3;
`endif

    typedef struct {
        logic [127:0] q;
        int           len;
    } cand_t;

    typedef struct {
        logic [127:0] lq;
        logic [4:0]   ll;
        logic [127:0] eq;
        int           el;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst, en, load;
    logic [127:0] load_q;
    logic [4:0]   load_len;
    logic         overflow;

    keyspace_gen_if ifc ();

    keyspace_gen #(
        .MAX_LEN (3),
        .CHAR_LO (8'h61),
        .CHAR_HI (8'h63)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .load     (load),
        .load_q   (load_q),
        .load_len (load_len),
        .cand     (ifc.master),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    n_xfer  = 0;
    bit    sb_on   = 1'b0;
    cand_t sbq[$];

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Reference: candidate as a base-NCH number, low char least significant.
    task automatic mnext(inout logic [127:0] mq, inout int ml,
                         output bit ov);
        longint val, base;
        val  = 0;
        base = 1;
        ov   = 1'b0;
        for (int i = 0; i < ml; i++) begin
            val  += longint'(mq[8*i +: 8] - LO) * base;
            base *= NCH;
        end
        val++;
        if (val >= base) begin
            if (VAR && ml < ML) begin
                ml++;
                val = 0;
            end else begin
                ov = 1'b1;
                return;
            end
        end
        mq = '0;
        for (int i = 0; i < ml; i++) begin
            mq[8*i +: 8] = LO + 8'(val % NCH);
            val = val / NCH;
        end
    endtask

    task automatic fill_sb(input logic [127:0] sq, input int sl);
        logic [127:0] mq;
        int           ml;
        bit           ov;
        mq = sq;
        ml = sl;
        ov = 1'b0;
        sbq.delete();
        while (!ov) begin
            sbq.push_back('{q: mq, len: ml});
            mnext(mq, ml, ov);
        end
        n_xfer = 0;
    endtask

    always @(negedge clk) begin
        if (sb_on && !rst && !load && ifc.out_valid && ifc.out_ready) begin
            n_xfer++;
            if (sbq.size() == 0) begin
                chk("sb_extra", ifc.q, '1);
            end else begin
                cand_t e;
                e = sbq.pop_front();
                chk("sb_q", ifc.q, e.q);
                chk("sb_len", 128'(ifc.len), 128'(e.len));
            end
        end
    end

    task automatic do_reset;
        rst = 1'b1;
        en = 1'b0;
        load = 1'b0;
        load_q = '0;
        load_len = '0;
        ifc.out_ready = 1'b0;
        step;
        step;
        rst = 1'b0;
    endtask

    task automatic run_to_ovf(input int budget, input bit rnd);
        for (int c = 0; c < budget && !overflow; c++) begin
            if (rnd) ifc.out_ready = 1'($urandom_range(0, 1));
            step;
        end
        chk("ovf_reached", 128'(overflow), 128'(1));
        sb_on = 1'b0;
        chk("sb_empty", 128'(sbq.size()), 128'(0));
    endtask

    vec_t vt[4];

    initial begin
        logic [127:0] sq;
        int           sl;
        bit           ov;

        vt[0] = '{lq: 128'h6363, ll: 5'd2,
                  eq: 128'h6363, el: VAR ? 2 : 3};
        vt[1] = '{lq: '1, ll: 5'd0,
                  eq: VAR ? 128'hFF : 128'hFFFFFF, el: VAR ? 1 : 3};
        vt[2] = '{lq: '1, ll: 5'd9,
                  eq: 128'hFFFFFF, el: 3};
        vt[3] = '{lq: 128'h626163, ll: 5'd3,
                  eq: 128'h626163, el: 3};

        // Reset values.
        do_reset;
        chk("rst_q", ifc.q, RSTQ);
        chk("rst_len", 128'(ifc.len), 128'(RSTL));
        chk("rst_valid", 128'(ifc.out_valid), 128'(0));
        chk("rst_ovf", 128'(overflow), 128'(0));

        // en rising, then full sweep to exhaustion.
        en = 1'b1;
        step;
        chk("en_valid", 128'(ifc.out_valid), 128'(1));
        chk("en_q", ifc.q, RSTQ);
        fill_sb(RSTQ, RSTL);
        sb_on = 1'b1;
        ifc.out_ready = 1'b1;
        run_to_ovf(200, 1'b0);
        chk("sweep_count", 128'(n_xfer), 128'(NTOT));
        chk("sweep_valid", 128'(ifc.out_valid), 128'(0));
        chk("sweep_last_q", ifc.q, 128'h636363);
        chk("sweep_last_len", 128'(ifc.len), 128'(3));

        // Load after exhaustion.
        load = 1'b1;
        load_q = 128'h636362;
        load_len = 5'd3;
        step;
        load = 1'b0;
        chk("ldx_ovf", 128'(overflow), 128'(0));
        chk("ldx_valid", 128'(ifc.out_valid), 128'(0));
        chk("ldx_q", ifc.q, 128'h636362);
        fill_sb(128'h636362, 3);
        sb_on = 1'b1;
        run_to_ovf(20, 1'b0);
        chk("ldx_count", 128'(n_xfer), 128'(2));

        // Backpressure 1,0,0,1 then random ready.
        do_reset;
        sq = RSTQ;
        sl = RSTL;
        mnext(sq, sl, ov);
        fill_sb(RSTQ, RSTL);
        sb_on = 1'b1;
        en = 1'b1;
        ifc.out_ready = 1'b1;
        step;
        step;
        ifc.out_ready = 1'b0;
        step;
        chk("bp_hold1_q", ifc.q, sq);
        chk("bp_hold1_v", 128'(ifc.out_valid), 128'(1));
        step;
        chk("bp_hold2_q", ifc.q, sq);
        chk("bp_hold2_v", 128'(ifc.out_valid), 128'(1));
        ifc.out_ready = 1'b1;
        step;
        run_to_ovf(1000, 1'b1);
        chk("bp_count", 128'(n_xfer), 128'(NTOT));

        // Load vector table.
        ifc.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            load = 1'b1;
            load_q = vt[i].lq;
            load_len = vt[i].ll;
            step;
            load = 1'b0;
            chk($sformatf("ld%0d_q", i), ifc.q, vt[i].eq);
            chk($sformatf("ld%0d_len", i), 128'(ifc.len), 128'(vt[i].el));
            chk($sformatf("ld%0d_v", i), 128'(ifc.out_valid), 128'(0));
            step;
            chk($sformatf("ld%0d_v1", i), 128'(ifc.out_valid), 128'(1));
        end

        // Load 0x6363 then consume two candidates.
        load = 1'b1;
        load_q = 128'h6363;
        load_len = 5'd2;
        step;
        load = 1'b0;
        ifc.out_ready = 1'b1;
        step;
        chk("ldg_q0", ifc.q, 128'h6363);
        chk("ldg_len0", 128'(ifc.len), 128'(VAR ? 2 : 3));
        step;
        chk("ldg_q1", ifc.q, VAR ? 128'h616161 : 128'h016161);
        chk("ldg_len1", 128'(ifc.len), 128'(3));

        // Reset during a stall.
        do_reset;
        en = 1'b1;
        step;
        step;
        chk("mr_valid_pre", 128'(ifc.out_valid), 128'(1));
        rst = 1'b1;
        step;
        rst = 1'b0;
        chk("mr_valid", 128'(ifc.out_valid), 128'(0));
        chk("mr_q", ifc.q, RSTQ);
        chk("mr_len", 128'(ifc.len), 128'(RSTL));
        fill_sb(RSTQ, RSTL);
        sb_on = 1'b1;
        ifc.out_ready = 1'b1;
        step;
        step;
        step;
        step;
        sb_on = 1'b0;
        chk("mr_count", 128'(n_xfer), 128'(3));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
